data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Memory-side responder for the Mips core's data port: accepts one load/store request at a time over a valid/ready handshake, accesses a word-organised RAM after a configurable latency, and returns a response over a second valid/ready handshake. It sits beside `Mips`, under the same top-level `clk`/`rst` the testbench drives, and replaces the ideal single-cycle data memory when multi-cycle memory is modelled.

## Interface
Parameters:
- `DEPTH_WORDS`, 256: number of 32-bit words; power of two, ≥ 2.
- `LATENCY`, 2: cycles from request accept to response valid; ≥ 1.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  synchronous active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data.
- `req_be`  in  4  byte enables; `req_be[i]` selects bits `8i+7:8i`.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  core accepts response.
- `resp_rdata`  out  32  load data; 0 for stores and errors.
- `resp_err`  out  1  request was misaligned or out of range.

## Operation
- States:
  - `IDLE`: `req_ready`=1. On `req_valid && req_ready`, latch `we`, `addr`, `wdata`, `be`; load `cnt`=`LATENCY-1`; go to `WAIT`.
  - `WAIT`: if `cnt`≠0, decrement. If `cnt`==0, perform the access, register the response, go to `RESP`.
  - `RESP`: `resp_valid`=1; hold `resp_rdata`/`resp_err` stable. On `resp_ready`, go to `IDLE`.
- Error: `addr[1:0]`≠0, or word index `addr>>2` ≥ `DEPTH_WORDS`. An errored request:
  - writes nothing;
  - returns `resp_rdata`=0 and `resp_err`=1.
- Store: merges only the enabled bytes into the word. `be`=0 is a legal no-op store. Response carries `resp_rdata`=0 and `resp_err`=0.
- Load: `resp_rdata` is the full word; `be` is ignored.
- RAM commits exactly on the `WAIT`→`RESP` edge. Requests are serialised, so a load after a store always sees the store.
- Reset:
  - `state`=`IDLE`, `cnt`=0, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0; `req_ready`=1 in the first cycle after reset.
  - RAM contents are not cleared.
  - A request in `WAIT` when `rst` is sampled is dropped; a pending store does not commit.
- `req_*` inputs are ignored outside `IDLE`.

## Timing
- `req_ready` and `resp_valid` are decoded from the registered state only; there is no combinational path from inputs to outputs.
- Accept at edge N gives `resp_valid`=1 from edge N+`LATENCY`.
- Response completes at the first edge with `resp_ready`=1 in `RESP`; `req_ready` returns at that edge.
- Minimum request-to-request spacing is `LATENCY`+2 cycles.
- `resp_ready` held high in `RESP` costs exactly one `RESP` cycle.
- `rst` has priority over every handshake in the same cycle.

## Structure
- Package `mem_pkg` holds:
  - state enum `{IDLE, WAIT, RESP}`;
  - `WORD_W`=32 and `BE_W`=4;
  - error-check helper function `addr_err(addr, depth)`.
- Sub-module `mips_word_ram`:
  - synchronous single-port RAM, `DEPTH_WORDS`×32, with per-byte write enables;
  - read data registered and muxed into `resp_rdata` on commit.
- The FSM and counter live in `data_mem_responder`.

## Test plan
All scenarios use `LATENCY`=2 and `DEPTH_WORDS`=256 unless noted.
- Reset: hold `rst`=1 for 2 cycles → `resp_valid`=0, `resp_err`=0, `resp_rdata`=0; `req_ready`=1 on the first post-reset cycle.
- Store/load:
  - store `0x10`, `0xDEADBEEF`, `be`=`4'hF`, accepted at edge N → `resp_valid` at N+2 with `resp_err`=0;
  - load `0x10` → `resp_rdata`=`0xDEADBEEF`.
- Byte enables: then store `0x11223344` to `0x10` with `be`=`4'b0101` → a load of `0x10` returns `0xDE22BE44`.
- Backpressure: hold `resp_ready`=0 for 5 cycles in `RESP` → `resp_valid`, `resp_rdata` and `resp_err` stay constant and `req_ready`=0; release → `IDLE` next edge.
- Errors:
  - load `0x12` → `resp_err`=1, `resp_rdata`=0;
  - store to `0x400` → `resp_err`=1;
  - words `0x100>>2` and `0x3FC>>2` are unchanged afterwards.
- Reset mid-operation: store `0xCAFEF00D` to `0x20`, assert `rst` in `WAIT` → no response; a later load of `0x20` returns its prior value.
- Latency sweep: repeat the store/load scenario with `LATENCY`=1 and `LATENCY`=5 → `resp_valid` at N+1 and N+5 respectively.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory responder: FSM states,
// word/byte-enable widths and the request address legality check.
package mem_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // A request is illegal if it is not word aligned or its word index is past the end of the RAM.
  function automatic logic addr_err(input logic [WORD_W-1:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[WORD_W-1:2]} >= depth);
  endfunction

endpackage

// File: rtl/mips_word_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// The read register only updates on a load access, so it holds steady while a response waits.
module mips_word_ram
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [BE_W-1:0]   i_be,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH_WORDS];
  logic [WORD_W-1:0] r_rdata;

  // NOTE: the storage array has no reset branch; clearing it would turn the RAM into flops and contents must survive rst.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < BE_W; b++) begin
          if (i_be[b]) begin
            r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
          end
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: one request at a time over valid/ready,
// RAM access after LATENCY cycles, response held until the core takes it.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int              AW       = $clog2(DEPTH_WORDS);
  localparam int              CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic [WORD_W-1:0] r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic [BE_W-1:0]   r_be;
  logic              r_err;
  logic              r_rd_sel;

  logic              w_accept;
  logic              w_commit;
  logic              w_resp_done;
  logic              w_err;
  logic [WORD_W-1:0] w_ram_rdata;

  assign w_accept    = (r_state == IDLE) && req_valid;
  assign w_commit    = (r_state == WAIT) && (r_cnt == '0);
  assign w_resp_done = (r_state == RESP) && resp_ready;
  assign w_err       = addr_err(r_addr, 32'(DEPTH_WORDS));

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: the default assignment first keeps this block purely combinational (no latch on unlisted paths).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept)    w_state_nxt = WAIT;
      WAIT:    if (w_commit)    w_state_nxt = RESP;
      RESP:    if (w_resp_done) w_state_nxt = IDLE;
      default:                  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_rd_sel <= 1'b0;
    end else begin
      if (w_accept)                         r_cnt <= CNT_INIT;
      else if (r_state == WAIT && !w_commit) r_cnt <= r_cnt - 1'b1;

      if (w_commit) begin
        r_err    <= w_err;
        r_rd_sel <= !r_we && !w_err;
      end else if (w_resp_done) begin
        r_err    <= 1'b0;
        r_rd_sel <= 1'b0;
      end
    end
  end

  // Request fields are only consumed after an accept, so they need no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= req_we;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_be    <= req_be;
    end
  end

  // Gating with rst drops a store whose commit edge coincides with reset.
  mips_word_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk     (clk),
    .i_en    (w_commit && !rst),
    .i_we    (r_we && !w_err),
    .i_addr  (r_addr[AW+1:2]),
    .i_wdata (r_wdata),
    .i_be    (r_be),
    .o_rdata (w_ram_rdata)
  );

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == RESP);
  assign resp_err   = r_err;
  assign resp_rdata = r_rd_sel ? w_ram_rdata : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: three instances (LATENCY 2, 1, 5) share clk/rst;
// drivers push expected responses, a negedge monitor pops and compares on each handshake.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_we     [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic [3:0]  req_be     [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic [31:0] resp_rdata [3];
  logic        resp_err   [3];

  typedef struct {
    int          k;
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_mem_responder #(
      .DEPTH_WORDS (256),
      .LATENCY     ((g == 0) ? 2 : ((g == 1) ? 1 : 5))
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_we     (req_we[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .req_be     (req_be[g]),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .resp_rdata (resp_rdata[g]),
      .resp_err   (resp_err[g])
    );
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 5);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 3; k++) begin
        if (resp_valid[k] === 1'b1 && resp_ready[k] === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_resp: dut%0d responded with rdata %h err %b, expected no response",
                     k, resp_rdata[k], resp_err[k]);
          end else begin
            mon_e = exp_q.pop_front();
            check({mon_e.name, "_dut"},   32'(k),        32'(mon_e.k));
            check({mon_e.name, "_rdata"}, resp_rdata[k], mon_e.rdata);
            check({mon_e.name, "_err"},   32'(resp_err[k]), 32'(mon_e.err));
          end
        end
      end
    end
  end

  task automatic drive_req(input int k, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
    @(negedge clk);
    check("req_ready_before_req", 32'(req_ready[k]), 32'd1);
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    req_be[k]    = be;
    @(posedge clk);
    #1;
    // Garbage on the request bus while busy must not leak into the latched request.
    req_valid[k] = 1'b0;
    req_we[k]    = ~we;
    req_addr[k]  = 32'hFFFF_FFF0;
    req_wdata[k] = 32'hA5A5_A5A5;
    req_be[k]    = 4'hF;
  endtask

  task automatic do_req(input int k, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] exp_rdata, input bit exp_err,
                        input string name, input bit hold);
    exp_t e;
    int   cyc;
    e.k = k; e.rdata = exp_rdata; e.err = exp_err; e.name = name;
    if (hold) resp_ready[k] = 1'b0;
    drive_req(k, we, addr, wdata, be);
    exp_q.push_back(e);
    cyc = 0;
    while (resp_valid[k] !== 1'b1 && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({name, "_latency"}, 32'(cyc), 32'(lat_of(k)));
    if (hold) begin
      repeat (5) begin
        @(posedge clk);
        #1;
        check({name, "_hold_valid"}, 32'(resp_valid[k]), 32'd1);
        check({name, "_hold_rdata"}, resp_rdata[k], exp_rdata);
        check({name, "_hold_err"},   32'(resp_err[k]), 32'(exp_err));
        check({name, "_hold_rdy"},   32'(req_ready[k]), 32'd0);
      end
      resp_ready[k] = 1'b1;
    end
    @(posedge clk);
    #1;
    check({name, "_done"}, {30'd0, resp_valid[k], req_ready[k]}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = '0;
      req_wdata[k] = '0;   req_be[k] = '0;   resp_ready[k] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("reset_resp_valid", 32'(resp_valid[k]), 32'd0);
      check("reset_resp_err",   32'(resp_err[k]),   32'd0);
      check("reset_resp_rdata", resp_rdata[k],       32'd0);
      check("reset_req_ready",  32'(req_ready[k]),  32'd1);
    end
    mon_en = 1'b1;

    do_req(0, 1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 0, "st_full", 0);
    do_req(0, 0, 32'h10, 32'h0,         4'h0, 32'hDEAD_BEEF, 0, "ld_full", 0);
    do_req(0, 1, 32'h10, 32'h1122_3344, 4'b0101, 32'h0, 0, "st_be", 0);
    do_req(0, 0, 32'h10, 32'h0,         4'h0, 32'hDE22_BE44, 0, "ld_be_bp", 1);

    do_req(0, 1, 32'h000, 32'h0000_A0A0, 4'hF, 32'h0, 0, "st_w0", 0);
    do_req(0, 1, 32'h100, 32'h1111_0100, 4'hF, 32'h0, 0, "st_w40", 0);
    do_req(0, 1, 32'h3FC, 32'h3333_03FC, 4'hF, 32'h0, 0, "st_wff", 0);
    do_req(0, 1, 32'h020, 32'h1234_5678, 4'hF, 32'h0, 0, "st_w8", 0);

    do_req(0, 0, 32'h012, 32'h0,         4'hF, 32'h0, 1, "ld_misalign", 0);
    do_req(0, 1, 32'h400, 32'hFFFF_FFFF, 4'hF, 32'h0, 1, "st_oor", 0);
    do_req(0, 1, 32'h102, 32'hFFFF_FFFF, 4'hF, 32'h0, 1, "st_misalign", 0);
    do_req(0, 1, 32'h7FC, 32'hFFFF_FFFF, 4'hF, 32'h0, 1, "st_oor_alias", 0);
    do_req(0, 1, 32'h000, 32'hFFFF_FFFF, 4'h0, 32'h0, 0, "st_be0", 0);
    do_req(0, 0, 32'h000, 32'h0, 4'h0, 32'h0000_A0A0, 0, "ld_w0", 0);
    do_req(0, 0, 32'h100, 32'h0, 4'h0, 32'h1111_0100, 0, "ld_w40", 0);
    do_req(0, 0, 32'h3FC, 32'h0, 4'h0, 32'h3333_03FC, 0, "ld_wff", 0);

    // Reset lands on the would-be commit edge of a pending store.
    drive_req(0, 1, 32'h20, 32'hCAFE_F00D, 4'hF);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rstmid_resp_valid", 32'(resp_valid[0]), 32'd0);
    check("rstmid_req_ready",  32'(req_ready[0]),  32'd1);
    repeat (4) @(posedge clk);
    #1;
    check("rstmid_no_resp", 32'(resp_valid[0]), 32'd0);
    do_req(0, 0, 32'h20, 32'h0, 4'h0, 32'h1234_5678, 0, "ld_after_rst", 0);

    for (int k = 1; k < 3; k++) begin
      do_req(k, 1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 0, "sweep_st", 0);
      do_req(k, 0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 0, "sweep_ld", 0);
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
